// File: rtl/line_follow_nav_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : line_follow_nav_ctrl
// Description : Line-following navigation controller. Synchronises and
//               debounces three IR line sensors, runs a follow / junction
//               manoeuvre / lost-line recovery state machine and drives a
//               registered 3-bit motion code for the motor-control stage.
//               Motion codes: 0 stop, 1 forward, 2 left drift, 3 right drift,
//               4 reverse, 5 left pivot, 6 right pivot (7 never driven).
// Ports       : clk            - system clock
//               rst            - asynchronous active-high reset
//               start          - single-cycle pulse, begin following
//               stop           - force halt (highest priority)
//               sensor[2:0]    - raw IR {L,C,R}, 1 = on line, async to clk
//               junction_dir   - action at next junction:
//                                0 straight, 1 left, 2 right, 3 u-turn
//               motion[2:0]    - registered motion code
//               busy           - high in every state except IDLE
//               lost           - sticky lost-line timeout flag
//               junction_count - junctions taken since start (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module line_follow_nav_ctrl #(
    parameter int DEBOUNCE_TICKS = 1000,
    parameter int TURN_TICKS     = 5000000,
    parameter int CROSS_TICKS    = 2000000,
    parameter int LOST_TICKS     = 10000000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] sensor,
    input  logic [1:0] junction_dir,
    output logic [2:0] motion,
    output logic       busy,
    output logic       lost,
    output logic [7:0] junction_count
);

    localparam int               c_db_w   = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DEBOUNCE_TICKS);
    localparam logic [c_db_w-1:0] c_db_one = c_db_w'(1);

    localparam logic [CNT_W-1:0] c_turn  = CNT_W'(TURN_TICKS);
    localparam logic [CNT_W-1:0] c_uturn = CNT_W'(2 * TURN_TICKS);
    localparam logic [CNT_W-1:0] c_cross = CNT_W'(CROSS_TICKS);
    localparam logic [CNT_W-1:0] c_lost  = CNT_W'(LOST_TICKS);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    localparam logic [2:0] c_mot_stop  = 3'd0;
    localparam logic [2:0] c_mot_fwd   = 3'd1;
    localparam logic [2:0] c_mot_left  = 3'd2;
    localparam logic [2:0] c_mot_right = 3'd3;
    localparam logic [2:0] c_mot_rev   = 3'd4;
    localparam logic [2:0] c_mot_lpiv  = 3'd5;
    localparam logic [2:0] c_mot_rpiv  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FOLLOW = 2'd1,
        S_TURN   = 2'd2,
        S_LOST   = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [c_db_w-1:0]  r_db_cnt;
    logic [2:0]         r_pat;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_dir;
    logic [2:0]         r_motion;
    logic               r_lost;
    logic [7:0]         r_jcnt;
    logic [CNT_W-1:0]   w_load;

    // Drift steering for the non-junction, non-empty patterns. Centred,
    // split (101) and full patterns all map to forward.
    function automatic logic [2:0] steer(input logic [2:0] p);
        case (p)
            3'b110, 3'b100: steer = c_mot_left;
            3'b011, 3'b001: steer = c_mot_right;
            default:        steer = c_mot_fwd;
        endcase
    endfunction

    // U-turn pivots right.
    function automatic logic [2:0] turn_code(input logic [1:0] d);
        case (d)
            2'd0:    turn_code = c_mot_fwd;
            2'd1:    turn_code = c_mot_lpiv;
            default: turn_code = c_mot_rpiv;
        endcase
    endfunction

    always_comb begin
        w_load = c_cross;
        case (junction_dir)
            2'd0:    w_load = c_cross;
            2'd3:    w_load = c_uturn;
            default: w_load = c_turn;
        endcase
    end

    // Sensor path. r_db_cnt counts how many cycles r_sync2 has held its
    // value; it restarts at 1 on the edge where r_sync2 takes a new value
    // (r_sync1 != r_sync2). Once it reaches the threshold the filtered
    // pattern follows r_sync2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_db_cnt <= '0;
            r_pat    <= 3'b000;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_db_cnt <= c_db_one;
            end else if (r_db_cnt != c_db_max) begin
                r_db_cnt <= r_db_cnt + c_db_one;
            end
            if (r_db_cnt == c_db_max) begin
                r_pat <= r_sync2;
            end
        end
    end

    // Navigation FSM; motion is registered alongside the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dir    <= 2'd0;
            r_motion <= c_mot_stop;
            r_lost   <= 1'b0;
            r_jcnt   <= 8'd0;
        end else if (stop) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_motion <= c_mot_stop;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_motion <= c_mot_stop;
                    if (start) begin
                        r_state  <= S_FOLLOW;
                        r_lost   <= 1'b0;
                        r_jcnt   <= 8'd0;
                        r_motion <= steer(r_pat);
                    end
                end
                S_FOLLOW: begin
                    if (r_pat == 3'b111) begin
                        r_dir    <= junction_dir;
                        r_jcnt   <= r_jcnt + 8'd1;
                        r_cnt    <= w_load;
                        r_state  <= S_TURN;
                        r_motion <= turn_code(junction_dir);
                    end else if (r_pat == 3'b000) begin
                        r_cnt    <= c_lost;
                        r_state  <= S_LOST;
                        r_motion <= c_mot_rev;
                    end else begin
                        r_motion <= steer(r_pat);
                    end
                end
                S_TURN: begin
                    // Leaving at count 1 makes the turn last exactly the
                    // loaded number of cycles.
                    if (r_cnt <= c_one) begin
                        r_cnt    <= '0;
                        r_state  <= S_FOLLOW;
                        r_motion <= steer(r_pat);
                    end else begin
                        r_cnt    <= r_cnt - c_one;
                        r_motion <= turn_code(r_dir);
                    end
                end
                S_LOST: begin
                    // Reacquiring the line wins over a same-cycle expiry.
                    if (r_pat != 3'b000) begin
                        r_cnt    <= '0;
                        r_state  <= S_FOLLOW;
                        r_motion <= steer(r_pat);
                    end else if (r_cnt <= c_one) begin
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                        r_lost   <= 1'b1;
                        r_motion <= c_mot_stop;
                    end else begin
                        r_cnt    <= r_cnt - c_one;
                        r_motion <= c_mot_rev;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_motion <= c_mot_stop;
                end
            endcase
        end
    end

    assign motion         = r_motion;
    assign busy           = (r_state != S_IDLE);
    assign lost           = r_lost;
    assign junction_count = r_jcnt;

endmodule
`default_nettype wire

// File: tb/tb_line_follow_nav_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_line_follow_nav_ctrl
// Description : Self-checking bench for line_follow_nav_ctrl. A cycle model
//               built from the behavioural rules (sample history for the
//               sensor filter, mode + remaining-cycles for manoeuvres) is
//               compared with the DUT after every clock, and directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_follow_nav_ctrl;

    localparam int D  = 4;
    localparam int TT = 20;
    localparam int CT = 10;
    localparam int LT = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] sensor;
    logic [1:0] jdir;
    logic [2:0] motion;
    logic       busy;
    logic       lost;
    logic [7:0] junction_count;

    always #5 clk = ~clk;

    line_follow_nav_ctrl #(
        .DEBOUNCE_TICKS (D),
        .TURN_TICKS     (TT),
        .CROSS_TICKS    (CT),
        .LOST_TICKS     (LT),
        .CNT_W          (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .sensor         (sensor),
        .junction_dir   (jdir),
        .motion         (motion),
        .busy           (busy),
        .lost           (lost),
        .junction_count (junction_count)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- model ----------------
    // m_mode: 0 idle, 1 follow, 2 turn, 3 lost
    int         m_mode;
    int         m_left;
    int         m_dir;
    int         m_motion;
    int         m_lost;
    int         m_jc;
    logic [2:0] m_pat;
    logic [2:0] hist[$];

    function automatic int drift(logic [2:0] p);
        if (p[2] && !p[0]) return 2;
        if (p[0] && !p[2]) return 3;
        return 1;
    endfunction

    function automatic int pivot(int d);
        if (d == 0) return 1;
        if (d == 1) return 5;
        return 6;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_dir = 0; m_motion = 0;
        m_lost = 0; m_jc = 0; m_pat = 3'b000;
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(3'b000);
    endtask

    task automatic model_step();
        logic [2:0] p;
        bit         same;
        p = m_pat;
        if (stop) begin
            m_mode = 0; m_motion = 0; m_left = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_motion = 0;
                    if (start) begin
                        m_mode = 1; m_lost = 0; m_jc = 0; m_motion = drift(p);
                    end
                end
                1: begin
                    if (p == 3'b111) begin
                        m_dir    = int'(jdir);
                        m_jc     = (m_jc + 1) % 256;
                        m_left   = (m_dir == 0) ? CT : ((m_dir == 3) ? 2 * TT : TT);
                        m_mode   = 2;
                        m_motion = pivot(m_dir);
                    end else if (p == 3'b000) begin
                        m_left = LT; m_mode = 3; m_motion = 4;
                    end else begin
                        m_motion = drift(p);
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 1; m_motion = drift(p); end
                    else m_motion = pivot(m_dir);
                end
                default: begin
                    if (p != 3'b000) begin
                        m_mode = 1; m_motion = drift(p);
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_mode = 0; m_lost = 1; m_motion = 0; end
                        else m_motion = 4;
                    end
                end
            endcase
        end
        // Filter: accept the sample from two edges ago once the last D
        // samples ending there all agree.
        hist.push_front(sensor);
        void'(hist.pop_back());
        same = 1'b1;
        for (int i = 3; i < D + 2; i++) if (hist[i] != hist[2]) same = 1'b0;
        if (same) m_pat = hist[2];
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees on this
    // edge, then compare all outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check("motion", int'(motion), m_motion);
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check("lost", int'(lost), m_lost);
        check("junction_count", int'(junction_count), m_jc);
        check("motion_not_7", (motion != 3'd7) ? 1 : 0, 1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_jc_change(input string name);
        int prev;
        int k;
        prev = int'(junction_count);
        k = 0;
        while (int'(junction_count) == prev && k < 20) begin tick(); k++; end
        check(name, (int'(junction_count) != prev) ? 1 : 0, 1);
    endtask

    task automatic wait_motion(input string name, input int code, input int limit);
        int k;
        k = 0;
        while (int'(motion) != code && k < limit) begin tick(); k++; end
        check(name, int'(motion), code);
    endtask

    // Counts consecutive observed cycles with motion == code, including the
    // current one.
    task automatic run_len(input int code, output int n);
        n = 0;
        while (int'(motion) == code && n < 200) begin n++; tick(); end
    endtask

    task automatic junction(input int dir, input logic [2:0] after, input int exp_code,
                            input int exp_len, input string name);
        int n;
        jdir = 2'(dir);
        sensor = 3'b111;
        wait_jc_change({name, "_taken"});
        sensor = after;
        jdir = 2'(3 - dir);   // later changes must not disturb the latched dir
        run_len(exp_code, n);
        check({name, "_cycles"}, n, exp_len);
    endtask

    int jsave;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; sensor = 3'b000; jdir = 2'd0;
        model_reset();
        ticks(2);
        rst = 1'b0;
        check("reset_motion", int'(motion), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_lost", int'(lost), 0);
        check("reset_jc", int'(junction_count), 0);

        // 1: settle 010, start
        sensor = 3'b010;
        ticks(8);
        start = 1'b1; tick(); start = 1'b0;
        check("t1_motion_fwd", int'(motion), 1);
        check("t1_busy", int'(busy), 1);
        check("t1_lost", int'(lost), 0);

        // 2: 3-cycle glitch rejected, long 110 accepted; start while busy ignored
        sensor = 3'b110; ticks(3);
        sensor = 3'b010; ticks(10);
        check("t2_glitch_rejected", int'(motion), 1);
        start = 1'b1; tick(); start = 1'b0;
        sensor = 3'b110; ticks(10);
        check("t2_left_drift", int'(motion), 2);
        sensor = 3'b011; ticks(10);
        check("t2_right_drift", int'(motion), 3);
        sensor = 3'b010; ticks(10);

        // 3: junction manoeuvres
        junction(1, 3'b010, 5, 20, "t3_left");
        check("t3_after_left", int'(motion), 1);
        check("t3_jc1", int'(junction_count), 1);
        ticks(4);
        junction(3, 3'b010, 6, 40, "t3_uturn");
        check("t3_jc2", int'(junction_count), 2);
        ticks(4);
        junction(0, 3'b110, 1, 10, "t3_cross");
        check("t3_after_cross", int'(motion), 2);
        sensor = 3'b010; ticks(10);

        // 5: stop + start together during a turn
        jdir = 2'd2; sensor = 3'b111;
        wait_jc_change("t5_taken");
        sensor = 3'b010; ticks(3);
        jsave = int'(junction_count);
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        check("t5_motion_stop", int'(motion), 0);
        check("t5_idle", int'(busy), 0);
        check("t5_jc_held", jsave, 4);
        check("t5_jc_value", int'(junction_count), 4);
        ticks(3);

        // 4: lost-line timeout, then recovery
        start = 1'b1; tick(); start = 1'b0;
        ticks(3);
        sensor = 3'b000;
        wait_motion("t4_enter_lost", 4, 20);
        begin
            int n;
            run_len(4, n);
            check("t4_reverse_cycles", n, 30);
        end
        check("t4_motion_stop", int'(motion), 0);
        check("t4_busy", int'(busy), 0);
        check("t4_lost_set", int'(lost), 1);
        start = 1'b1; tick(); start = 1'b0;
        check("t4_lost_cleared", int'(lost), 0);
        ticks(15);
        sensor = 3'b010;
        wait_motion("t4_recover", 1, 20);
        check("t4_recover_busy", int'(busy), 1);
        check("t4_recover_lost", int'(lost), 0);
        ticks(4);

        // 6: async reset mid-turn
        jdir = 2'd1; sensor = 3'b111;
        wait_jc_change("t6_taken");
        sensor = 3'b010; ticks(5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_motion", int'(motion), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_lost", int'(lost), 0);
        check("t6_async_jc", int'(junction_count), 0);
        ticks(2);
        rst = 1'b0;
        ticks(8);
        start = 1'b1; tick(); start = 1'b0;
        jdir = 2'd0;
        for (int i = 0; i < 256; i++) begin
            sensor = 3'b111;
            wait_jc_change("t6_wrap_taken");
            if (i == 254) check("t6_jc_255", int'(junction_count), 255);
            sensor = 3'b010;
            ticks(12);
        end
        check("t6_jc_wrapped", int'(junction_count), 0);
        check("t6_wrap_busy", int'(busy), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
